// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO reader engine.
// The optional stall statistics are enabled with READER_STATS_EN.
package fifo_reader_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_t;

   localparam int unsigned BUF_DEPTH = 2;
   localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry register buffer that absorbs FIFO read data ahead of the output stream.
// Supports a simultaneous push and pop in the same cycle.
module fifo_reader_buf
   import fifo_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] head_o,
   output logic [BUF_CNT_W-1:0]  count_o
);

   localparam logic [BUF_CNT_W-1:0] BufFull = BUF_CNT_W'(BUF_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [BUF_CNT_W-1:0]  count_q, count_d;
   logic                  push_ok, pop_ok;

   // A push into a full buffer is only legal when the head leaves in the same cycle.
   assign push_ok = push_i & ((count_q != BufFull) | pop_i);
   assign pop_ok  = pop_i & (count_q != '0);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q + BUF_CNT_W'(push_ok) - BUF_CNT_W'(pop_ok);
      if (push_ok) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
         end
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fifo_reader.sv
// Consumer-side FIFO engine: pops a burst of len words and forwards them on a valid/ready stream.
// Define READER_STATS_EN to add the stall_cnt_o backpressure counter.
module fifo_reader
   import fifo_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   output logic                  fifo_rden_o,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  busy_o,
   output logic                  done_o
`ifdef READER_STATS_EN
   ,
   output logic [15:0]           stall_cnt_o
`endif
);

   rd_state_t             state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  issued_q, issued_d;
   logic [LEN_WIDTH-1:0]  delivered_q, delivered_d;
   logic                  inflight_q;
   logic [BUF_CNT_W-1:0]  buf_cnt;
   logic [BUF_CNT_W:0]    occupancy;
   logic                  has_credit;
   logic                  xfer;
   logic                  start_acc;

   fifo_reader_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (inflight_q),
      .data_i  (fifo_rdata_i),
      .pop_i   (xfer),
      .head_o  (m_data_o),
      .count_o (buf_cnt)
   );

   assign m_valid_o = (buf_cnt != '0);
   assign xfer      = m_valid_o & m_ready_i;

   // A word leaving the buffer this cycle frees its slot in time for the next push,
   // which is what allows one pop per cycle under steady flow.
   assign occupancy  = {1'b0, buf_cnt} + {{BUF_CNT_W{1'b0}}, inflight_q}
                       - {{BUF_CNT_W{1'b0}}, xfer};
   assign has_credit = occupancy < (BUF_CNT_W + 1)'(BUF_DEPTH);

   assign fifo_rden_o = (state_q == RUN) & ~fifo_empty_i & (issued_q < len_q) & has_credit;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      issued_d    = issued_q + LEN_WIDTH'(fifo_rden_o);
      delivered_d = delivered_q + LEN_WIDTH'(xfer);
      start_acc   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               start_acc   = 1'b1;
               len_d       = len_i;
               issued_d    = '0;
               delivered_d = '0;
               state_d     = (len_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (issued_q == len_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Look at the updated count so done lands one cycle after the last transfer.
            if (delivered_d == len_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         len_q       <= '0;
         issued_q    <= '0;
         delivered_q <= '0;
         inflight_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         delivered_q <= delivered_d;
         inflight_q  <= fifo_rden_o;
      end
   end

   assign busy_o = (state_q == RUN) | (state_q == DRAIN);
   assign done_o = (state_q == DONE);

`ifdef READER_STATS_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (start_acc) begin
         stall_d = '0;
      end else if (m_valid_o & ~m_ready_i & (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: FIFO model, stream scoreboard and per-scenario tasks.
// Build with READER_STATS_EN defined to also check the stall counter.
module tb_fifo_reader;
   import fifo_reader_pkg::*;

   localparam int DW = 8;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic          fifo_rden;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_rdata = '0;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          busy;
   logic          done;
`ifdef READER_STATS_EN
   logic [15:0]   stall_cnt;
`endif

   fifo_reader #(
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .len_i        (len),
      .fifo_rden_o  (fifo_rden),
      .fifo_empty_i (fifo_empty),
      .fifo_rdata_i (fifo_rdata),
      .m_valid_o    (m_valid),
      .m_ready_i    (m_ready),
      .m_data_o     (m_data),
      .busy_o       (busy),
      .done_o       (done)
`ifdef READER_STATS_EN
      ,
      .stall_cnt_o  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int            rden_log[$];
   int            xfer_log[$];
   int            done_log[$];
   bit            busy_seen;
   bit            hold_valid = 1'b0;
   logic [DW-1:0] hold_data;

   // FIFO model: registered read data one cycle after an accepted pop.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rden && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
   end

   // Monitor and scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy) busy_seen = 1'b1;
         if (done) done_log.push_back(cyc);
         if (fifo_rden) begin
            rden_log.push_back(cyc);
            n_checks++;
            if (fifo_empty !== 1'b0) begin
               n_errors++;
               $display("FAIL rden_while_empty: cycle %0d got empty=%b, required 0", cyc, fifo_empty);
            end
         end
         if (hold_valid) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== hold_data) begin
               n_errors++;
               $display("FAIL hold_stable: cycle %0d got valid=%b data=%h, required 1/%h",
                        cyc, m_valid, m_data, hold_data);
            end
         end
         if (m_valid && m_ready) begin
            xfer_log.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_word: cycle %0d got %h, required none", cyc, m_data);
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               if (m_data !== e) begin
                  n_errors++;
                  $display("FAIL stream_data: cycle %0d got %h, required %h", cyc, m_data, e);
               end
            end
         end
         hold_valid = m_valid && !m_ready;
         hold_data  = m_data;
      end else begin
         hold_valid = 1'b0;
      end
   end

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rden_log.delete();
      xfer_log.delete();
      done_log.delete();
      busy_seen = 1'b0;
   endtask

   task automatic push_word(input logic [DW-1:0] d, input bit expect_out);
      fifo_q.push_back(d);
      if (expect_out) exp_q.push_back(d);
   endtask

   task automatic start_burst(input logic [LW-1:0] l, output int sc);
      sc    = cyc;
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (done_log.size() > 0) break;
         tick();
      end
      n_checks++;
      if (done_log.size() == 0) begin
         n_errors++;
         $display("FAIL %s_timeout: got no done within %0d cycles, required done", name, budget);
      end
   endtask

   task automatic chk(input string name, input int got, input int req);
      n_checks++;
      if (got !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      start   = 1'b0;
      len     = '0;
      m_ready = 1'b0;
      tick();
      tick();
      chk("reset_rden", int'(fifo_rden), 0);
      chk("reset_valid", int'(m_valid), 0);
      chk("reset_data", int'(m_data), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
`ifdef READER_STATS_EN
      chk("reset_stall", int'(stall_cnt), 0);
`endif
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int sc;
      clear_logs();
      m_ready = 1'b1;
      for (int i = 1; i <= 4; i++) push_word(DW'(i), 1'b1);
      start_burst(4, sc);
      wait_done(40, "basic");
      tick();
      chk("basic_rden_count", rden_log.size(), 4);
      chk("basic_first_rden", at(rden_log, 0), sc + 1);
      chk("basic_rden_consec", at(rden_log, 3), sc + 4);
      chk("basic_xfer_count", xfer_log.size(), 4);
      chk("basic_latency", at(xfer_log, 0), sc + 3);
      chk("basic_xfer_consec", at(xfer_log, 3), sc + 6);
      chk("basic_done_cycle", at(done_log, 0), sc + 7);
      chk("basic_sb_empty", exp_q.size(), 0);
   endtask

   task automatic test_len_zero();
      int sc;
      clear_logs();
      start_burst(0, sc);
      repeat (4) tick();
      chk("len0_done_count", done_log.size(), 1);
      chk("len0_done_cycle", at(done_log, 0), sc + 1);
      chk("len0_no_rden", rden_log.size(), 0);
      chk("len0_busy_seen", int'(busy_seen), 0);
   endtask

   task automatic test_backpressure();
      int sc;
      int nst;
      clear_logs();
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push_word(DW'(8'h10 + i), 1'b1);
      start_burst(8, sc);
      nst = 0;
      for (int i = 0; i < 30; i++) begin
         if (m_valid) begin
            if (nst == 5) break;
            nst++;
         end
         tick();
      end
      chk("bp_stall_cycles", nst, 5);
      chk("bp_rden_before_release", rden_log.size(), 2);
      m_ready = 1'b1;
      wait_done(60, "bp");
      tick();
      chk("bp_xfer_count", xfer_log.size(), 8);
      chk("bp_rden_count", rden_log.size(), 8);
      chk("bp_sb_empty", exp_q.size(), 0);
`ifdef READER_STATS_EN
      chk("bp_stall_cnt", int'(stall_cnt), 5);
`endif
   endtask

   task automatic test_empty_mid();
      int sc;
      clear_logs();
      m_ready = 1'b1;
      push_word(8'hC1, 1'b1);
      push_word(8'hC2, 1'b1);
      start_burst(3, sc);
      repeat (10) tick();
      chk("empty_state_run", int'(dut.state_q === RUN), 1);
      chk("empty_busy", int'(busy), 1);
      chk("empty_rden_count", rden_log.size(), 2);
      chk("empty_no_done", done_log.size(), 0);
      push_word(8'hC3, 1'b1);
      wait_done(30, "empty");
      tick();
      chk("empty_third_latency", at(xfer_log, 2), at(rden_log, 2) + 2);
      chk("empty_done_cycle", at(done_log, 0), at(xfer_log, 2) + 1);
      chk("empty_sb_empty", exp_q.size(), 0);
   endtask

   task automatic test_reset_mid();
      int sc;
      int n;
      clear_logs();
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) push_word(DW'(8'h60 + i), 1'b0);
      start_burst(6, sc);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (n == 2) break;
         if (fifo_rden) n++;
         tick();
      end
      chk("rstmid_two_rden", n, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid_rden", int'(fifo_rden), 0);
      chk("rstmid_valid", int'(m_valid), 0);
      chk("rstmid_data", int'(m_data), 0);
      chk("rstmid_busy", int'(busy), 0);
      chk("rstmid_done", int'(done), 0);
      fifo_q.delete();
      tick();
      clear_logs();
      push_word(8'hA5, 1'b1);
      tick();
      start_burst(1, sc);
      wait_done(30, "rstmid");
      tick();
      chk("rstmid_new_xfer", xfer_log.size(), 1);
      chk("rstmid_new_latency", at(xfer_log, 0), sc + 3);
      chk("rstmid_sb_empty", exp_q.size(), 0);
   endtask

   task automatic test_start_busy();
      int sc;
      int sc2;
      clear_logs();
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) push_word(DW'(8'h30 + i), 1'b1);
      for (int i = 0; i < 3; i++) push_word(DW'(8'hE0 + i), 1'b0);
      start_burst(3, sc);
      tick();
      start_burst(9, sc2);
      wait_done(40, "startbusy");
      repeat (6) tick();
      chk("sb_rden_count", rden_log.size(), 3);
      chk("sb_xfer_count", xfer_log.size(), 3);
      chk("sb_done_count", done_log.size(), 1);
      chk("sb_busy_idle", int'(busy), 0);
      chk("sb_sb_empty", exp_q.size(), 0);
      fifo_q.delete();
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_zero();
      test_backpressure();
      test_empty_mid();
      test_reset_mid();
      test_start_busy();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by 200000, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
